// File: rtl/exec_control_pkg.sv
// cpu_pkg: shared opcode, state and instruction-field definitions for the 16-bit CPU
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RA_HI = 7;
  localparam int RA_LO = 4;
  localparam int RB_HI = 3;
  localparam int RB_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_JMP  = 4'h9,
    OP_BZ   = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALTED    = 3'd4
  } state_t;
endpackage

// File: rtl/exec_control_alu.sv
// alu: combinational 16-bit ALU producing result, carry/borrow and zero
module alu
  import cpu_pkg::*;
(
  input  opcode_t     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        c,
  output logic        z
);
  logic [16:0] sum;
  logic [16:0] dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = op == OP_ADD ? sum[15:0] :
             op == OP_SUB ? dif[15:0] :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b :
             op == OP_SHL ? a << b[3:0] :
             op == OP_SHR ? a >> b[3:0] : 16'h0000;
    c = op == OP_ADD ? sum[16] : op == OP_SUB ? dif[16] : 1'b0;
    z = result == 16'h0000;
  end
endmodule

// File: rtl/exec_control.sv
// exec_control: multi-cycle fetch/decode/execute/writeback controller with integrated ALU
module exec_control
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              rf_en_read,
  output logic [3:0]        rf_ra_addr,
  output logic [3:0]        rf_rb_addr,
  input  logic [15:0]       rf_ra,
  input  logic [15:0]       rf_rb,
  output logic              rf_en_write,
  output logic [3:0]        rf_rd_addr,
  output logic [15:0]       rf_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic              illegal
);
  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [15:0]          result;
  logic [3:0]           opc;
  logic [15:0]          alu_y;
  logic                 alu_c;
  logic                 alu_z;
  logic                 is_alu;
  logic                 is_undef;
  logic [ADDR_W-1:0]    pc_inc;
  assign opc      = ir[OP_HI:OP_LO];
  assign is_alu   = opc inside {[4'h1:4'h7]};
  assign is_undef = opc inside {[4'hB:4'hE]};
  assign pc_inc   = pc + ADDR_W'(1);
  // enables are gated by reset so an in-flight fetch or writeback is dropped at once
  assign imem_req    = state == S_FETCH && !reset;
  assign rf_en_read  = state == S_DECODE && !reset;
  assign rf_en_write = state == S_WRITEBACK && !reset;
  assign imem_addr   = pc;
  assign rf_ra_addr  = ir[RA_HI:RA_LO];
  assign rf_rb_addr  = ir[RB_HI:RB_LO];
  assign rf_rd_addr  = ir[RD_HI:RD_LO];
  assign rf_wdata    = result;
  assign halted      = state == S_HALTED;
  alu u_alu (
    .op    (opcode_t'(opc)),
    .a     (rf_ra),
    .b     (rf_rb),
    .result(alu_y),
    .c     (alu_c),
    .z     (alu_z)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) begin
          ir    <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          if (is_alu) begin
            result <= alu_y;
            flag_z <= alu_z;
            flag_c <= alu_c;
            state  <= S_WRITEBACK;
          end else if (opc == OP_LDI) begin
            result <= {8'h00, ir[IMM_HI:IMM_LO]};
            state  <= S_WRITEBACK;
          end else if (opc == OP_JMP) begin
            pc    <= ADDR_W'(rf_ra);
            state <= S_FETCH;
          end else if (opc == OP_BZ) begin
            pc    <= rf_ra == 16'h0000 ? ADDR_W'(rf_rb) : pc_inc;
            state <= S_FETCH;
          end else if (opc == OP_HALT) begin
            state <= S_HALTED;
          end else begin
            illegal <= illegal | is_undef;
            pc      <= pc_inc;
            state   <= S_FETCH;
          end
        end
        S_WRITEBACK: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_control.sv
// tb_exec_control: directed self-checking bench for exec_control
module tb_exec_control;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        rf_en_read;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [15:0] rf_ra = 16'h0000;
  logic [15:0] rf_rb = 16'h0000;
  logic        rf_en_write;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_wdata;
  logic [15:0] pc;
  logic        flag_z;
  logic        flag_c;
  logic        halted;
  logic        illegal;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc = 16'h0000;

  exec_control #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_en_read(rf_en_read), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra(rf_ra), .rf_rb(rf_rb),
    .rf_en_write(rf_en_write), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .pc(pc), .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b);
    imem_data = instr;
    imem_ack  = 1'b1;
    rf_ra     = a;
    rf_rb     = b;
    tick;
    imem_ack  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if ({halted, illegal, flag_z, flag_c} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {halted, illegal, flag_z, flag_c}); end
    checks++; if ({rf_en_read, rf_en_write} !== 2'b00) begin errors++; $display("FAIL reset_en got %b exp 00", {rf_en_read, rf_en_write}); end
    checks++; if ({rf_wdata, rf_rd_addr, rf_ra_addr, rf_rb_addr} !== 28'h0) begin errors++; $display("FAIL reset_rf got %h exp 0", {rf_wdata, rf_rd_addr, rf_ra_addr, rf_rb_addr}); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch0 got req %b addr %h exp 1 0000", imem_req, imem_addr); end
  endtask

  task automatic test_ldi;
    issue(16'h8105, 16'h0000, 16'h0000);
    checks++; if ({rf_en_read, rf_en_write} !== 2'b10) begin errors++; $display("FAIL ldi_decode got %b exp 10", {rf_en_read, rf_en_write}); end
    tick;
    checks++; if ({rf_en_read, rf_en_write} !== 2'b00) begin errors++; $display("FAIL ldi_exec got %b exp 00", {rf_en_read, rf_en_write}); end
    tick;
    checks++; if (rf_en_write !== 1'b1 || rf_rd_addr !== 4'd1 || rf_wdata !== 16'h0005 || rf_en_read !== 1'b0) begin
      errors++; $display("FAIL ldi_wb got we %b rd %h wd %h exp 1 1 0005", rf_en_write, rf_rd_addr, rf_wdata);
    end
    tick;
    exp_pc = 16'h0001;
    checks++; if (pc !== exp_pc || imem_req !== 1'b1) begin errors++; $display("FAIL ldi_pc got %h req %b exp %h 1", pc, imem_req, exp_pc); end
  endtask

  task automatic test_alu;
    logic [15:0] ins [9] = '{16'h1312, 16'h2421, 16'h3123, 16'h4123, 16'h5123, 16'h6123, 16'h7123, 16'h7123, 16'h2321};
    logic [15:0] va  [9] = '{16'hFFFF, 16'h0001, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000, 16'hABCD, 16'h0005};
    logic [15:0] vb  [9] = '{16'h0001, 16'h0003, 16'hFF00, 16'h0F00, 16'hF0F0, 16'h000F, 16'h0014, 16'h0000, 16'h0005};
    logic [15:0] ey  [9] = '{16'h0000, 16'hFFFE, 16'hF000, 16'hFFF0, 16'h0000, 16'h8000, 16'h0800, 16'hABCD, 16'h0000};
    logic        ez  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ec  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] cur;
    for (int i = 0; i < 9; i++) begin
      cur = ins[i];
      issue(cur, va[i], vb[i]);
      checks++; if (rf_ra_addr !== cur[7:4] || rf_rb_addr !== cur[3:0]) begin errors++; $display("FAIL alu%0d_addr got %h %h exp %h %h", i, rf_ra_addr, rf_rb_addr, cur[7:4], cur[3:0]); end
      tick;
      tick;
      checks++; if (rf_en_write !== 1'b1 || rf_rd_addr !== cur[11:8] || rf_wdata !== ey[i]) begin
        errors++; $display("FAIL alu%0d_wb got we %b rd %h wd %h exp 1 %h %h", i, rf_en_write, rf_rd_addr, rf_wdata, cur[11:8], ey[i]);
      end
      checks++; if (flag_z !== ez[i] || flag_c !== ec[i]) begin errors++; $display("FAIL alu%0d_flags got z%b c%b exp z%b c%b", i, flag_z, flag_c, ez[i], ec[i]); end
      tick;
      exp_pc = exp_pc + 16'd1;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL alu%0d_pc got %h exp %h", i, pc, exp_pc); end
    end
  endtask

  task automatic test_fetch_wait;
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || rf_en_read !== 1'b0 || rf_en_write !== 1'b0) begin
        errors++; $display("FAIL wait%0d got req %b addr %h rd %b wr %b exp 1 %h 0 0", i, imem_req, imem_addr, rf_en_read, rf_en_write, exp_pc);
      end
    end
    issue(16'h8A7F, 16'h1111, 16'h2222);
    checks++; if (rf_en_read !== 1'b1) begin errors++; $display("FAIL wait_decode got %b exp 1", rf_en_read); end
    tick;
    tick;
    checks++; if (rf_en_write !== 1'b1 || rf_rd_addr !== 4'hA || rf_wdata !== 16'h007F) begin errors++; $display("FAIL wait_ldi got we %b rd %h wd %h exp 1 a 007f", rf_en_write, rf_rd_addr, rf_wdata); end
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin errors++; $display("FAIL ldi_keeps_flags got z%b c%b exp z1 c0", flag_z, flag_c); end
    tick;
    exp_pc = exp_pc + 16'd1;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wait_pc got %h exp %h", pc, exp_pc); end
  endtask

  task automatic test_branch;
    issue(16'hA034, 16'h0000, 16'h0040);
    tick;
    checks++; if (rf_en_write !== 1'b0) begin errors++; $display("FAIL bz_exec_we got %b exp 0", rf_en_write); end
    tick;
    checks++; if (pc !== 16'h0040 || rf_en_write !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL bz_taken got pc %h we %b req %b exp 0040 0 1", pc, rf_en_write, imem_req); end
    issue(16'hA034, 16'h0007, 16'h0040);
    tick;
    tick;
    checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL bz_not_taken got %h exp 0041", pc); end
    issue(16'h9050, 16'h1234, 16'h0000);
    tick;
    tick;
    exp_pc = 16'h1234;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jmp got %h exp %h", pc, exp_pc); end
  endtask

  task automatic test_illegal;
    issue(16'hC000, 16'h0000, 16'h0000);
    tick;
    tick;
    exp_pc = exp_pc + 16'd1;
    checks++; if (illegal !== 1'b1 || pc !== exp_pc) begin errors++; $display("FAIL illegal got ill %b pc %h exp 1 %h", illegal, pc, exp_pc); end
    checks++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin errors++; $display("FAIL illegal_flags got z%b c%b exp z1 c0", flag_z, flag_c); end
    issue(16'h0000, 16'h0000, 16'h0000);
    tick;
    tick;
    exp_pc = exp_pc + 16'd1;
    checks++; if (illegal !== 1'b1 || pc !== exp_pc) begin errors++; $display("FAIL illegal_sticky got ill %b pc %h exp 1 %h", illegal, pc, exp_pc); end
  endtask

  task automatic test_halt;
    issue(16'hF000, 16'h0000, 16'h0000);
    tick;
    tick;
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin errors++; $display("FAIL halt got h %b req %b pc %h exp 1 0 %h", halted, imem_req, pc, exp_pc); end
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    imem_ack = 1'b0;
    checks++; if (halted !== 1'b1 || {imem_req, rf_en_read, rf_en_write} !== 3'b000 || pc !== exp_pc) begin
      errors++; $display("FAIL halt_hold got h %b en %b pc %h exp 1 000 %h", halted, {imem_req, rf_en_read, rf_en_write}, pc, exp_pc);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    exp_pc = 16'h0000;
    checks++; if (halted !== 1'b0 || illegal !== 1'b0 || pc !== exp_pc || imem_req !== 1'b1) begin
      errors++; $display("FAIL halt_reset got h %b ill %b pc %h req %b exp 0 0 0000 1", halted, illegal, pc, imem_req);
    end
  endtask

  task automatic test_reset_writeback;
    issue(16'h8203, 16'h0000, 16'h0000);
    tick;
    tick;
    tick;
    issue(16'h1312, 16'hFFFF, 16'h0001);
    tick;
    tick;
    checks++; if (rf_en_write !== 1'b1 || flag_z !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL rwb_pre got we %b z%b c%b exp 1 1 1", rf_en_write, flag_z, flag_c); end
    reset = 1'b1;
    #1;
    checks++; if (rf_en_write !== 1'b0) begin errors++; $display("FAIL rwb_gate got %b exp 0", rf_en_write); end
    tick;
    checks++; if (pc !== 16'h0000 || {flag_z, flag_c, illegal, halted} !== 4'b0000 || rf_wdata !== 16'h0000 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rwb_post got pc %h flags %b wd %h req %b exp 0000 0000 0000 0", pc, {flag_z, flag_c, illegal, halted}, rf_wdata, imem_req);
    end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || rf_en_write !== 1'b0) begin errors++; $display("FAIL rwb_fetch got req %b addr %h we %b exp 1 0000 0", imem_req, imem_addr, rf_en_write); end
  endtask

  initial begin
    test_reset;
    test_ldi;
    test_alu;
    test_fetch_wait;
    test_branch;
    test_illegal;
    test_halt;
    test_reset_writeback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
